// File: rtl/sid_dac_pkg.sv
// rtl/sid_dac_pkg.sv - frame geometry and receiver state shared by the SID DAC link ends
package sid_dac_pkg;

  localparam int FRAME_BITS = 16;
  localparam int DATA_BITS  = 12;
  localparam int CFG_BITS   = FRAME_BITS - DATA_BITS;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } rx_state_e;

endpackage

// File: rtl/sid_dac_rx_if.sv
// rtl/sid_dac_rx_if.sv - serial DAC link pins plus the deserialised sample side
interface sid_dac_rx_if
  import sid_dac_pkg::*;
#(
  parameter int PERIOD_W = 16
);

  logic                 spi_clk;
  logic                 spi_le;
  logic                 spi_dat_1;
  logic                 spi_dat_2;
  logic [DATA_BITS-1:0] sample_out_1;
  logic [DATA_BITS-1:0] sample_out_2;
  logic [CFG_BITS-1:0]  cfg_out_1;
  logic [CFG_BITS-1:0]  cfg_out_2;
  logic                 sample_valid;
  logic                 frame_err;
  logic [PERIOD_W-1:0]  period;

  modport slave (
    input  spi_clk, spi_le, spi_dat_1, spi_dat_2,
    output sample_out_1, sample_out_2, cfg_out_1, cfg_out_2,
    output sample_valid, frame_err, period
  );

  modport master (
    output spi_clk, spi_le, spi_dat_1, spi_dat_2,
    input  sample_out_1, sample_out_2, cfg_out_1, cfg_out_2,
    input  sample_valid, frame_err, period
  );

endinterface

// File: rtl/sid_sync_edge.sv
// rtl/sid_sync_edge.sv - N-flop synchroniser with one-clk rise/fall strobes
module sid_sync_edge #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic rise_o,
  output logic fall_o
);

  logic [STAGES-1:0] sync_q;
  logic              prev_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= {STAGES{RST_VAL}};
      prev_q <= RST_VAL;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
      prev_q <= sync_q[STAGES-1];
    end
  end

  assign rise_o =  sync_q[STAGES-1] & ~prev_q;
  assign fall_o = ~sync_q[STAGES-1] &  prev_q;

endmodule

// File: rtl/sid_dac_rx.sv
// rtl/sid_dac_rx.sv - two-lane serial DAC receiver: deserialise, frame check, sample period
module sid_dac_rx
  import sid_dac_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int PERIOD_W    = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  sid_dac_rx_if.slave  bus
);

  localparam int                 BCW     = $clog2(FRAME_BITS + 2);
  localparam logic [BCW-1:0]     BC_FULL = BCW'(FRAME_BITS);
  localparam logic [BCW-1:0]     BC_MAX  = BCW'(FRAME_BITS + 1);
  localparam logic [BCW-1:0]     BC_ONE  = BCW'(1);
  localparam logic [PERIOD_W-1:0] P_ONE  = PERIOD_W'(1);

  logic clk_rise, le_rise, le_fall;
  logic unused_clk_fall;
  logic [SYNC_STAGES-1:0] dat1_sync_q, dat2_sync_q;
  logic dat1, dat2;

  rx_state_e             state_q, state_d;
  logic [FRAME_BITS-1:0] sh1_q, sh1_d, sh2_q, sh2_d;
  logic [BCW-1:0]        bitcnt_q, bitcnt_d;
  logic [DATA_BITS-1:0]  smp1_q, smp1_d, smp2_q, smp2_d;
  logic [CFG_BITS-1:0]   cfg1_q, cfg1_d, cfg2_q, cfg2_d;
  logic                  valid_q, valid_d, err_q, err_d;
  logic [PERIOD_W-1:0]   pcnt_q, pcnt_d, period_q, period_d, pcnt_inc;

  sid_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_clk_sync (
    .clk    (clk),
    .rst_n  (rst_n),
    .d_i    (bus.spi_clk),
    .rise_o (clk_rise),
    .fall_o (unused_clk_fall)
  );

  sid_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_le_sync (
    .clk    (clk),
    .rst_n  (rst_n),
    .d_i    (bus.spi_le),
    .rise_o (le_rise),
    .fall_o (le_fall)
  );

  // Same depth as the spi_clk chain so the bit lands with its detected rising edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dat1_sync_q <= '0;
      dat2_sync_q <= '0;
    end else begin
      dat1_sync_q <= {dat1_sync_q[SYNC_STAGES-2:0], bus.spi_dat_1};
      dat2_sync_q <= {dat2_sync_q[SYNC_STAGES-2:0], bus.spi_dat_2};
    end
  end

  assign dat1     = dat1_sync_q[SYNC_STAGES-1];
  assign dat2     = dat2_sync_q[SYNC_STAGES-1];
  assign pcnt_inc = (pcnt_q == '1) ? pcnt_q : pcnt_q + P_ONE;

  always_comb begin
    state_d  = state_q;
    sh1_d    = sh1_q;
    sh2_d    = sh2_q;
    bitcnt_d = bitcnt_q;
    smp1_d   = smp1_q;
    smp2_d   = smp2_q;
    cfg1_d   = cfg1_q;
    cfg2_d   = cfg2_q;
    valid_d  = 1'b0;
    err_d    = 1'b0;
    pcnt_d   = pcnt_inc;
    period_d = period_q;

    case (state_q)
      IDLE: begin
        if (le_fall) begin
          state_d  = SHIFT;
          sh1_d    = '0;
          sh2_d    = '0;
          bitcnt_d = '0;
        end
      end
      SHIFT: begin
        // A bit arriving with the latch edge is shifted before the count is judged.
        if (clk_rise) begin
          sh1_d = {sh1_q[FRAME_BITS-2:0], dat1};
          sh2_d = {sh2_q[FRAME_BITS-2:0], dat2};
          if (bitcnt_q != BC_MAX) bitcnt_d = bitcnt_q + BC_ONE;
        end
        if (le_rise) begin
          state_d = IDLE;
          if (bitcnt_d == BC_FULL) begin
            smp1_d   = sh1_d[DATA_BITS-1:0];
            smp2_d   = sh2_d[DATA_BITS-1:0];
            cfg1_d   = sh1_d[FRAME_BITS-1:DATA_BITS];
            cfg2_d   = sh2_d[FRAME_BITS-1:DATA_BITS];
            valid_d  = 1'b1;
            period_d = pcnt_inc;
            pcnt_d   = '0;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      sh1_q    <= '0;
      sh2_q    <= '0;
      bitcnt_q <= '0;
      smp1_q   <= '0;
      smp2_q   <= '0;
      cfg1_q   <= '0;
      cfg2_q   <= '0;
      valid_q  <= 1'b0;
      err_q    <= 1'b0;
      pcnt_q   <= '0;
      period_q <= '0;
    end else begin
      state_q  <= state_d;
      sh1_q    <= sh1_d;
      sh2_q    <= sh2_d;
      bitcnt_q <= bitcnt_d;
      smp1_q   <= smp1_d;
      smp2_q   <= smp2_d;
      cfg1_q   <= cfg1_d;
      cfg2_q   <= cfg2_d;
      valid_q  <= valid_d;
      err_q    <= err_d;
      pcnt_q   <= pcnt_d;
      period_q <= period_d;
    end
  end

  assign bus.sample_out_1 = smp1_q;
  assign bus.sample_out_2 = smp2_q;
  assign bus.cfg_out_1    = cfg1_q;
  assign bus.cfg_out_2    = cfg2_q;
  assign bus.sample_valid = valid_q;
  assign bus.frame_err    = err_q;
  assign bus.period       = period_q;

endmodule

// File: tb/tb_sid_dac_rx.sv
// tb/tb_sid_dac_rx.sv - directed bench for sid_dac_rx
module tb_sid_dac_rx;
  import sid_dac_pkg::*;

  localparam int PH   = 4;
  localparam int SYNC = 2;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  sid_dac_rx_if #(.PERIOD_W(16)) bus();

  sid_dac_rx #(.SYNC_STAGES(SYNC), .PERIOD_W(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int valid_cnt = 0, err_cnt = 0, overlap_cnt = 0, valid_cyc = 0;
  always @(negedge clk) begin
    if (bus.sample_valid) begin
      valid_cnt = valid_cnt + 1;
      valid_cyc = cyc;
    end
    if (bus.frame_err) err_cnt = err_cnt + 1;
    if (bus.sample_valid && bus.frame_err) overlap_cnt = overlap_cnt + 1;
  end

  int checks = 0, failures = 0;
  int le_cyc, rst_cyc, v0, e0, la;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Frame start to spi_le rise is PH + nbits*2*PH + PH clks (136 for 16 bits).
  task automatic send_frame(input logic [15:0] d1, input logic [15:0] d2,
                            input int nbits, input bit merge_last);
    bus.spi_le = 1'b0;
    wait_clks(PH);
    for (int i = 0; i < nbits; i++) begin
      bus.spi_clk   = 1'b0;
      bus.spi_dat_1 = (i < 16) ? d1[15-i] : 1'b0;
      bus.spi_dat_2 = (i < 16) ? d2[15-i] : 1'b0;
      wait_clks(PH);
      bus.spi_clk = 1'b1;
      if (merge_last && i == nbits - 1) begin
        bus.spi_le = 1'b1;
        le_cyc     = cyc;
        wait_clks(PH);
        bus.spi_clk = 1'b0;
        wait_clks(PH);
        return;
      end
      wait_clks(PH);
    end
    bus.spi_clk = 1'b0;
    wait_clks(PH);
    bus.spi_le = 1'b1;
    le_cyc     = cyc;
    wait_clks(PH);
  endtask

  task automatic wait_until(input int target);
    while (cyc < target) wait_clks(1);
  endtask

  task automatic chk_out(input string tag, input logic [11:0] s1, input logic [3:0] c1,
                         input logic [11:0] s2, input logic [3:0] c2);
    chk({tag, "_s1"}, 32'(bus.sample_out_1), 32'(s1));
    chk({tag, "_c1"}, 32'(bus.cfg_out_1),    32'(c1));
    chk({tag, "_s2"}, 32'(bus.sample_out_2), 32'(s2));
    chk({tag, "_c2"}, 32'(bus.cfg_out_2),    32'(c2));
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.spi_clk   = 1'b0;
    bus.spi_le    = 1'b1;
    bus.spi_dat_1 = 1'b0;
    bus.spi_dat_2 = 1'b0;
    wait_clks(3);
    chk_out("rst", 12'h0, 4'h0, 12'h0, 4'h0);
    chk("rst_period", 32'(bus.period), 32'h0);
    chk("rst_valid", 32'(bus.sample_valid), 32'h0);
    chk("rst_err", 32'(bus.frame_err), 32'h0);
    rst_n = 1'b1;
    rst_cyc = cyc;
    wait_clks(5);

    // basic frame, latency, first period since reset
    v0 = valid_cnt; e0 = err_cnt;
    send_frame(16'h3ABC, 16'h1234, 16, 1'b0);
    wait_clks(8);
    chk_out("t1", 12'hABC, 4'h3, 12'h234, 4'h1);
    chk("t1_nvalid", 32'(valid_cnt - v0), 32'd1);
    chk("t1_latency", 32'(valid_cyc - le_cyc), 32'(SYNC + 1));
    chk("t1_nerr", 32'(err_cnt - e0), 32'd0);
    chk("t1_period", 32'(bus.period), 32'(le_cyc + 3 - rst_cyc));

    // short and long frames after a good one
    send_frame(16'h0FFF, 16'h0001, 16, 1'b0);
    wait_clks(8);
    v0 = valid_cnt; e0 = err_cnt;
    send_frame(16'hFFFF, 16'hFFFF, 15, 1'b0);
    wait_clks(8);
    send_frame(16'hFFFF, 16'hFFFF, 17, 1'b0);
    wait_clks(8);
    chk("t2_nerr", 32'(err_cnt - e0), 32'd2);
    chk("t2_nvalid", 32'(valid_cnt - v0), 32'd0);
    chk_out("t2", 12'hFFF, 4'h0, 12'h001, 4'h0);

    // period of 500 between good commits
    send_frame(16'h0111, 16'h0222, 16, 1'b0);
    la = le_cyc;
    wait_until(la + 500 - 136);
    send_frame(16'h0333, 16'h0444, 16, 1'b0);
    wait_clks(8);
    chk("t3_period", 32'(bus.period), 32'd500);

    // bad frame in between does not disturb the period
    send_frame(16'h0555, 16'h0666, 16, 1'b0);
    la = le_cyc;
    e0 = err_cnt;
    wait_clks(8);
    send_frame(16'h1234, 16'h5678, 15, 1'b0);
    wait_until(la + 500 - 136);
    send_frame(16'h0777, 16'h0888, 16, 1'b0);
    wait_clks(8);
    chk("t3b_nerr", 32'(err_cnt - e0), 32'd1);
    chk("t3b_period", 32'(bus.period), 32'd500);
    chk_out("t3b", 12'h777, 4'h0, 12'h888, 4'h0);

    // saturation after a long silence
    wait_clks(70000);
    send_frame(16'h9ABC, 16'h6DEF, 16, 1'b0);
    wait_clks(8);
    chk("t4_period", 32'(bus.period), 32'hFFFF);
    chk_out("t4", 12'hABC, 4'h9, 12'hDEF, 4'h6);

    // reset in the middle of a frame
    v0 = valid_cnt; e0 = err_cnt;
    bus.spi_le = 1'b0;
    wait_clks(PH);
    for (int i = 0; i < 8; i++) begin
      bus.spi_clk   = 1'b0;
      bus.spi_dat_1 = i[0];
      bus.spi_dat_2 = ~i[0];
      wait_clks(PH);
      bus.spi_clk = 1'b1;
      wait_clks(PH);
    end
    rst_n       = 1'b0;
    bus.spi_le  = 1'b1;
    bus.spi_clk = 1'b0;
    #1;
    chk_out("t5_rst", 12'h0, 4'h0, 12'h0, 4'h0);
    chk("t5_rst_period", 32'(bus.period), 32'h0);
    wait_clks(3);
    chk("t5_rst_valid", 32'(bus.sample_valid), 32'h0);
    rst_n   = 1'b1;
    rst_cyc = cyc;
    wait_clks(5);
    send_frame(16'h5555, 16'hAAAA, 16, 1'b0);
    wait_clks(8);
    chk("t5_nvalid", 32'(valid_cnt - v0), 32'd1);
    chk("t5_nerr", 32'(err_cnt - e0), 32'd0);
    chk_out("t5", 12'h555, 4'h5, 12'hAAA, 4'hA);
    chk("t5_period", 32'(bus.period), 32'(le_cyc + 3 - rst_cyc));

    // last bit and latch edge together
    v0 = valid_cnt; e0 = err_cnt;
    wait_clks(8);
    send_frame(16'hC123, 16'h4567, 16, 1'b1);
    wait_clks(8);
    chk("t6_nvalid", 32'(valid_cnt - v0), 32'd1);
    chk("t6_nerr", 32'(err_cnt - e0), 32'd0);
    chk("t6_latency", 32'(valid_cyc - le_cyc), 32'(SYNC + 1));
    chk_out("t6", 12'h123, 4'hC, 12'h567, 4'h4);

    chk("exclusive_pulses", 32'(overlap_cnt), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
